// File: rtl/barrel_shift_arbiter.sv
// rtl/barrel_shift_arbiter.sv - four-requester round-robin front end for one shared barrel shifter
module barrel_shift_arbiter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] req_data,
    input  logic [4*SHW-1:0]   req_amt,
    input  logic [3:0]         req_dir,
    input  logic [3:0]         req_rot,
    output logic [3:0]         gnt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_id,
    input  logic               out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic             accept_ok;
    logic             gnt_any;
    logic [1:0]       gnt_idx;
    logic [1:0]       cand;

    logic [WIDTH-1:0] sel_data;
    logic [SHW-1:0]   sel_amt;
    logic             sel_dir;
    logic             sel_rot;
    logic [WIDTH-1:0] stage [0:SHW];

    // The result slot can take a new command when empty or when it is drained this cycle
    assign accept_ok = rst_n && ((state == EMPTY) || out_ready);

    // Round-robin search from ptr upward, first pending requester wins
    always_comb begin
        gnt     = 4'b0000;
        gnt_idx = 2'd0;
        gnt_any = 1'b0;
        cand    = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (accept_ok && !gnt_any && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_any   = 1'b1;
            end
        end
    end

    // Only the granted requester's fields reach the shifter, so others cannot disturb the result
    assign sel_data = req_data[gnt_idx*WIDTH +: WIDTH];
    assign sel_amt  = req_amt[gnt_idx*SHW +: SHW];
    assign sel_dir  = req_dir[gnt_idx];
    assign sel_rot  = req_rot[gnt_idx];

    assign stage[0] = sel_data;

    // One mux stage per shift-amount bit; stage k moves by 2**k positions
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int S = 1 << k;
        logic [WIDTH-1:0] shl;
        logic [WIDTH-1:0] shr;

        assign shl = sel_rot ? {stage[k][WIDTH-1-S:0], stage[k][WIDTH-1:WIDTH-S]}
                             : {stage[k][WIDTH-1-S:0], {S{1'b0}}};
        assign shr = sel_rot ? {stage[k][S-1:0], stage[k][WIDTH-1:S]}
                             : {{S{1'b0}}, stage[k][WIDTH-1:S]};
        assign stage[k+1] = sel_amt[k] ? (sel_dir ? shr : shl) : stage[k];
    end

    // Result slot FSM: load on grant, drain on out_ready, clear everything on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ptr      <= 2'd0;
            out_data <= '0;
            out_id   <= 2'd0;
        end else if (gnt_any) begin
            state    <= FULL;
            ptr      <= gnt_idx + 2'd1;
            out_data <= stage[SHW];
            out_id   <= gnt_idx;
        end else if ((state == FULL) && out_ready) begin
            state    <= EMPTY;
        end
    end

    assign out_valid = (state == FULL);

endmodule
